// File: rtl/pc_unit.sv
// MIPS32 fetch-stage program counter: sequential fetch, delay-slot-aware branch
// redirect, exception/ERET redirect, and stall / not-ready tolerance.
module pc_unit #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_INC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              fetch_ready_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              exc_req_i,
  input  logic [ADDR_W-1:0] exc_pc_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              in_ds_o,
  output logic              addr_err_o,
  output logic              br_pend_o
);

  localparam logic [ADDR_W-1:0] RV  = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_BR_PEND = 2'd2
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [ADDR_W-1:0] r_pc,       w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_tgt, w_pend_tgt_nxt;
  logic              r_pc_valid, w_pc_valid_nxt;
  logic              r_in_ds,    w_in_ds_nxt;
  logic              w_advance;

  // Sequential fetch address; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] inc_pc(input logic [ADDR_W-1:0] pc);
    return pc + INC;
  endfunction

  assign w_advance = fetch_ready_i & ~stall_i & r_pc_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pc_valid_nxt = r_pc_valid;
    w_in_ds_nxt    = r_in_ds;
    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_RUN;
        w_pc_valid_nxt = 1'b1;
      end
      S_RUN, S_BR_PEND: begin
        if (exc_req_i) begin
          w_pc_nxt       = exc_pc_i;
          w_state_nxt    = S_RUN;
          w_pend_tgt_nxt = '0;
          w_in_ds_nxt    = 1'b0;
        end else if (eret_i) begin
          w_pc_nxt       = epc_i;
          w_state_nxt    = S_RUN;
          w_pend_tgt_nxt = '0;
          w_in_ds_nxt    = 1'b0;
        end else if (r_state == S_BR_PEND && w_advance) begin
          // Delay slot accepted this cycle; now redirect to the held target.
          w_pc_nxt       = r_pend_tgt;
          w_state_nxt    = S_RUN;
          w_pend_tgt_nxt = '0;
          w_in_ds_nxt    = 1'b0;
        end else if (r_state == S_RUN && br_taken_i && w_advance) begin
          w_pc_nxt    = br_target_i;
          w_in_ds_nxt = 1'b0;
        end else if (r_state == S_RUN && br_taken_i) begin
          w_pend_tgt_nxt = br_target_i;
          w_state_nxt    = S_BR_PEND;
          w_in_ds_nxt    = 1'b1;
        end else if (w_advance) begin
          w_pc_nxt    = inc_pc(r_pc);
          w_in_ds_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_pc_valid_nxt = 1'b0;
        w_in_ds_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RV;
      r_pend_tgt <= '0;
      r_pc_valid <= 1'b0;
      r_in_ds    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pc_valid <= w_pc_valid_nxt;
      r_in_ds    <= w_in_ds_nxt;
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_pc_valid;
  assign in_ds_o    = r_in_ds;
  assign addr_err_o = |r_pc[1:0];
  assign br_pend_o  = (r_state == S_BR_PEND);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for fetch/branch/exception
// sequencing and an 8-bit instance for wrap, truncated reset vector and misalignment.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 32-bit instance
  logic        rst, stall, fr, br, exc, eret;
  logic [31:0] br_tgt, exc_pc, epc;
  logic [31:0] pc;
  logic        valid, in_ds, aerr, bpend;

  pc_unit #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000), .PC_INC(4)) u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(fr),
    .br_taken_i(br), .br_target_i(br_tgt), .exc_req_i(exc), .exc_pc_i(exc_pc),
    .eret_i(eret), .epc_i(epc), .pc_o(pc), .pc_valid_o(valid),
    .in_ds_o(in_ds), .addr_err_o(aerr), .br_pend_o(bpend)
  );

  // 8-bit instance; reset vector 0x120 truncates to 0x20
  logic       rst_b, stall_b, fr_b, br_b, exc_b, eret_b;
  logic [7:0] br_tgt_b, exc_pc_b, epc_b;
  logic [7:0] pc_b;
  logic       valid_b, in_ds_b, aerr_b, bpend_b;

  pc_unit #(.ADDR_W(8), .RESET_VECTOR(32'h0000_0120), .PC_INC(4)) u_dut8 (
    .clk(clk), .rst(rst_b), .stall_i(stall_b), .fetch_ready_i(fr_b),
    .br_taken_i(br_b), .br_target_i(br_tgt_b), .exc_req_i(exc_b), .exc_pc_i(exc_pc_b),
    .eret_i(eret_b), .epc_i(epc_b), .pc_o(pc_b), .pc_valid_o(valid_b),
    .in_ds_o(in_ds_b), .addr_err_o(aerr_b), .br_pend_o(bpend_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; fr = 1'b1; br = 1'b0; exc = 1'b0; eret = 1'b0;
    br_tgt = '0; exc_pc = '0; epc = '0;
    rst_b = 1'b1; stall_b = 1'b0; fr_b = 1'b1; br_b = 1'b0; exc_b = 1'b0; eret_b = 1'b0;
    br_tgt_b = '0; exc_pc_b = '0; epc_b = '0;

    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_in_ds", {31'b0, in_ds}, 32'h0);
    check("rst_br_pend", {31'b0, bpend}, 32'h0);

    rst = 1'b0;
    step(); check("idle_to_run_pc", pc, 32'h0);
    check("idle_to_run_valid", {31'b0, valid}, 32'h1);
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8);
    step(); check("seq_pc12", pc, 32'hC);
    step(); check("seq_pc16", pc, 32'h10);

    // Branch with no stall: one-cycle redirect
    br = 1'b1; br_tgt = 32'h100;
    step(); br = 1'b0;
    check("br_nostall_pc", pc, 32'h100);
    check("br_nostall_ds", {31'b0, in_ds}, 32'h0);
    check("br_nostall_pend", {31'b0, bpend}, 32'h0);

    eret = 1'b1; epc = 32'h14;
    step(); eret = 1'b0;
    check("eret_pc", pc, 32'h14);

    // Branch during a 3-cycle stall
    stall = 1'b1; br = 1'b1; br_tgt = 32'h200;
    step(); br = 1'b0;
    check("stall_br_c1_pc", pc, 32'h14);
    check("stall_br_c1_pend", {31'b0, bpend}, 32'h1);
    check("stall_br_c1_ds", {31'b0, in_ds}, 32'h1);
    br = 1'b1; br_tgt = 32'h300;
    step(); br = 1'b0;
    check("stall_br_c2_pc", pc, 32'h14);
    check("stall_br_c2_pend", {31'b0, bpend}, 32'h1);
    step();
    check("stall_br_c3_pc", pc, 32'h14);
    check("stall_br_c3_ds", {31'b0, in_ds}, 32'h1);
    stall = 1'b0;
    step();
    check("stall_br_tgt_pc", pc, 32'h200);
    check("stall_br_tgt_pend", {31'b0, bpend}, 32'h0);
    check("stall_br_tgt_ds", {31'b0, in_ds}, 32'h0);

    // Exception overrides a pending branch, ignoring stall and not-ready
    stall = 1'b1; fr = 1'b0; br = 1'b1; br_tgt = 32'h200;
    step(); br = 1'b0;
    check("pend2_pend", {31'b0, bpend}, 32'h1);
    exc = 1'b1; exc_pc = 32'h180;
    step(); exc = 1'b0;
    check("exc_pc", pc, 32'h180);
    check("exc_pend", {31'b0, bpend}, 32'h0);
    check("exc_ds", {31'b0, in_ds}, 32'h0);
    stall = 1'b0; fr = 1'b1;
    step(); check("exc_cleared_tgt", pc, 32'h184);

    // Exception beats ERET beats branch
    exc = 1'b1; exc_pc = 32'h180; eret = 1'b1; epc = 32'h40; br = 1'b1; br_tgt = 32'h300;
    step(); exc = 1'b0;
    check("exc_eret_br_pc", pc, 32'h180);
    step(); eret = 1'b0; br = 1'b0;
    check("eret_br_pc", pc, 32'h40);
    step(); check("after_eret_seq", pc, 32'h44);

    fr = 1'b0;
    step(); check("not_ready_hold", pc, 32'h44);
    fr = 1'b1;

    // Async reset while a branch is pending
    stall = 1'b1; br = 1'b1; br_tgt = 32'h500;
    step(); br = 1'b0;
    check("pend3_pend", {31'b0, bpend}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pend", {31'b0, bpend}, 32'h0);
    check("async_rst_valid", {31'b0, valid}, 32'h0);
    check("async_rst_ds", {31'b0, in_ds}, 32'h0);
    step(); rst = 1'b0; stall = 1'b0;
    step(); check("post_rst_idle_pc", pc, 32'h0);
    step(); check("post_rst_no_tgt", pc, 32'h4);

    // 8-bit instance: truncated reset vector, IDLE ignores exception, wrap, misalignment
    check("b_rst_pc", {24'b0, pc_b}, 32'h20);
    rst_b = 1'b0; exc_b = 1'b1; exc_pc_b = 8'h80;
    step(); exc_b = 1'b0;
    check("b_idle_exc_ignored", {24'b0, pc_b}, 32'h20);
    check("b_valid", {31'b0, valid_b}, 32'h1);
    eret_b = 1'b1; epc_b = 8'hFC;
    step(); eret_b = 1'b0;
    check("b_eret_fc", {24'b0, pc_b}, 32'hFC);
    check("b_aerr_aligned", {31'b0, aerr_b}, 32'h0);
    step(); check("b_wrap", {24'b0, pc_b}, 32'h00);
    eret_b = 1'b1; epc_b = 8'h42;
    step(); eret_b = 1'b0;
    check("b_misaligned_pc", {24'b0, pc_b}, 32'h42);
    check("b_addr_err", {31'b0, aerr_b}, 32'h1);
    step(); check("b_misaligned_seq", {24'b0, pc_b}, 32'h46);
    check("b_addr_err2", {31'b0, aerr_b}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
